// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bundle: start control, SRAM read port, instruction
// handshake towards decode, redirect inputs and status outputs.
// The master modport is the sequencer itself; slave is its environment.
interface fetch_sequencer_if #(
    parameter int ADDR  = 4,
    parameter int WIDTH = 8
);
    logic             start;
    logic             mem_cs;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;
    logic             jump_en;
    logic [ADDR-1:0]  jump_addr;
    logic [ADDR-1:0]  pc;
    logic             busy;
    logic             halted;

    modport master (
        input  start,
        input  mem_data,
        input  instr_ready,
        input  jump_en,
        input  jump_addr,
        output mem_cs,
        output mem_addr,
        output instr,
        output instr_valid,
        output pc,
        output busy,
        output halted
    );

    modport slave (
        output start,
        output mem_data,
        output instr_ready,
        output jump_en,
        output jump_addr,
        input  mem_cs,
        input  mem_addr,
        input  instr,
        input  instr_valid,
        input  pc,
        input  busy,
        input  halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for a single-port synchronous SRAM with a
// one-cycle registered read. Each instruction costs one REQ cycle (chip
// select), one CAPT cycle (data returns) and at least one VALID cycle
// (held until decode accepts it). A HALT_OP opcode parks the sequencer.
module fetch_sequencer #(
    parameter int              ADDR    = 4,
    parameter int              WIDTH   = 8,
    parameter int              OPW     = 4,
    parameter logic [OPW-1:0]  HALT_OP = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CAPT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t           state_q;
    logic [ADDR-1:0]  pc_q;
    logic [ADDR-1:0]  pc_d;
    logic [WIDTH-1:0] instr_q;
    logic             instr_valid_q;
    logic             halted_q;
    logic             handshake;
    logic             is_halt;

    // Sequential increment wraps naturally at 2^ADDR.
    assign pc_d      = pc_q + ADDR'(1);
    assign handshake = instr_valid_q & bus.instr_ready;
    assign is_halt   = (instr_q[WIDTH-1 -: OPW] == HALT_OP);

    // Fetch FSM: owns state, pc, instruction register and halt flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q  <= REQ;
                        halted_q <= 1'b0;
                    end
                end
                REQ: begin
                    state_q <= CAPT;
                end
                CAPT: begin
                    // SRAM output is valid only in this cycle.
                    instr_q       <= bus.mem_data;
                    pc_q          <= pc_d;
                    instr_valid_q <= 1'b1;
                    state_q       <= VALID;
                end
                VALID: begin
                    if (handshake) begin
                        instr_valid_q <= 1'b0;
                        if (is_halt) begin
                            // Halt wins over any redirect; pc stays put so a
                            // later start resumes after the halt word.
                            halted_q <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            if (bus.jump_en) begin
                                pc_q <= bus.jump_addr;
                            end
                            state_q <= REQ;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // SRAM port is decoded straight from state so the read issues in REQ.
    assign bus.mem_cs      = (state_q == REQ);
    assign bus.mem_addr    = (state_q == REQ) ? pc_q : '0;

    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: in-order fetch, backpressure,
// redirect, pc wrap, halt/restart and asynchronous reset mid-read.
module tb_fetch_sequencer;

    logic clk;
    logic rst;
    logic [7:0] mem [16];
    int n_tests;
    int n_fail;

    fetch_sequencer_if #(.ADDR(4), .WIDTH(8)) bus ();

    fetch_sequencer #(
        .ADDR(4), .WIDTH(8), .OPW(4), .HALT_OP(4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM model: data registered one cycle after chip select.
    initial bus.mem_data = 8'h00;
    always @(posedge clk) begin
        if (bus.mem_cs) bus.mem_data <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete fetch: REQ, CAPT, VALID (+hold), handshake.
    task automatic expect_fetch(input logic [3:0] addr, input logic [7:0] word,
                                input int hold, input bit jmp, input logic [3:0] jaddr,
                                input bit noise, input int exp_n);
        int n;
        logic [3:0] nxt;
        n = 0;
        nxt = addr + 4'd1;
        while (!bus.mem_cs && n < 12) begin
            step();
            n++;
        end
        check("cs_seen", bus.mem_cs, 1);
        if (exp_n >= 0) check("cs_latency", n, exp_n);
        check("req_addr", bus.mem_addr, addr);
        if (noise) begin
            bus.jump_en = 1'b1;
            bus.jump_addr = 4'h7;
            bus.start = 1'b1;
        end
        step();
        check("capt_cs", bus.mem_cs, 0);
        check("capt_addr", bus.mem_addr, 0);
        check("capt_valid", bus.instr_valid, 0);
        step();
        bus.jump_en = 1'b0;
        bus.start = 1'b0;
        check("valid", bus.instr_valid, 1);
        check("instr", bus.instr, word);
        check("pc_inc", bus.pc, nxt);
        check("busy", bus.busy, 1);
        check("halted_pre", bus.halted, 0);
        if (hold > 0) begin
            bus.instr_ready = 1'b0;
            if (noise) begin
                bus.jump_en = 1'b1;
                bus.jump_addr = 4'h7;
            end
            for (int i = 0; i < hold; i++) begin
                step();
                check("hold_valid", bus.instr_valid, 1);
                check("hold_instr", bus.instr, word);
                check("hold_cs", bus.mem_cs, 0);
                check("hold_pc", bus.pc, nxt);
            end
        end
        bus.instr_ready = 1'b1;
        bus.jump_en = jmp;
        bus.jump_addr = jaddr;
        step();
        bus.jump_en = 1'b0;
        check("hs_valid", bus.instr_valid, 0);
        $display("[TB] fetch addr=%h instr=%h jump=%0d hold=%0d", addr, word, jmp, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.instr_ready = 1'b0;
        bus.jump_en = 1'b0;
        bus.jump_addr = 4'h0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h12; mem[1] = 8'h24; mem[2] = 8'h50; mem[3] = 8'h15;
        mem[4] = 8'h31; mem[5] = 8'h66;
        mem[10] = 8'h4A; mem[11] = 8'h5B; mem[12] = 8'h6C; mem[13] = 8'h7D;
        mem[14] = 8'h1F; mem[15] = 8'h2F;

        @(negedge clk);
        @(negedge clk);
        check("rst_cs", bus.mem_cs, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_pc", bus.pc, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_halted", bus.halted, 0);
        rst = 1'b0;
        step();
        check("idle_busy", bus.busy, 0);
        check("idle_cs", bus.mem_cs, 0);

        // In-order fetch with backpressure on the second word.
        bus.instr_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        expect_fetch(4'h0, 8'h12, 0, 1'b0, 4'h0, 1'b0, 0);
        expect_fetch(4'h1, 8'h24, 5, 1'b0, 4'h0, 1'b1, 0);
        expect_fetch(4'h2, 8'h50, 0, 1'b0, 4'h0, 1'b0, 0);
        expect_fetch(4'h3, 8'h15, 0, 1'b0, 4'h0, 1'b0, 0);

        // Redirect to 0xA, with jump/start noise during REQ/CAPT.
        expect_fetch(4'h4, 8'h31, 0, 1'b1, 4'hA, 1'b1, 0);
        expect_fetch(4'hA, 8'h4A, 0, 1'b0, 4'h0, 1'b0, 0);
        expect_fetch(4'hB, 8'h5B, 0, 1'b0, 4'h0, 1'b0, 0);
        expect_fetch(4'hC, 8'h6C, 0, 1'b0, 4'h0, 1'b0, 0);
        expect_fetch(4'hD, 8'h7D, 0, 1'b0, 4'h0, 1'b0, 0);

        // Wrap 14 -> 15 -> 0.
        expect_fetch(4'hE, 8'h1F, 0, 1'b0, 4'h0, 1'b0, 0);
        expect_fetch(4'hF, 8'h2F, 0, 1'b0, 4'h0, 1'b0, 0);
        mem[3] = 8'hF3;
        expect_fetch(4'h0, 8'h12, 0, 1'b0, 4'h0, 1'b0, 0);
        expect_fetch(4'h1, 8'h24, 0, 1'b0, 4'h0, 1'b0, 0);
        expect_fetch(4'h2, 8'h50, 0, 1'b0, 4'h0, 1'b0, 0);

        // Halt word accepted together with an ignored jump request.
        expect_fetch(4'h3, 8'hF3, 0, 1'b1, 4'h9, 1'b0, 0);
        check("halt_halted", bus.halted, 1);
        check("halt_busy", bus.busy, 0);
        check("halt_pc", bus.pc, 4'h4);
        check("halt_cs", bus.mem_cs, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("parked_cs", bus.mem_cs, 0);
            check("parked_busy", bus.busy, 0);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("restart_halted", bus.halted, 0);
        check("restart_busy", bus.busy, 1);
        expect_fetch(4'h4, 8'h31, 0, 1'b0, 4'h0, 1'b0, 0);

        // Asynchronous reset while the read of address 5 is in CAPT.
        check("pre_rst_cs", bus.mem_cs, 1);
        check("pre_rst_addr", bus.mem_addr, 4'h5);
        step();
        check("capt_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_cs", bus.mem_cs, 0);
        check("arst_pc", bus.pc, 0);
        check("arst_instr", bus.instr, 0);
        check("arst_valid", bus.instr_valid, 0);
        check("arst_halted", bus.halted, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_valid", bus.instr_valid, 0);
            check("post_rst_instr", bus.instr, 0);
            check("post_rst_busy", bus.busy, 0);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        expect_fetch(4'h0, 8'h12, 0, 1'b0, 4'h0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the single-port synchronous instruction SRAM: chip select asserted one cycle → registered data one cycle later.
- Owns the program counter and issues one read per instruction.
- Captures the SRAM word into an instruction register and presents it to the decode/execute stage over a valid/ready handshake.
- Supports PC redirect (jump) on handshake and stops on a halt opcode.

Parameters:
- ADDR, 4, address width / PC width.
- WIDTH, 8, instruction word width.
- OPW, 4, opcode field width (instr[WIDTH-1:WIDTH-OPW]).
- HALT_OP, 4'hF, opcode value that halts fetching.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  begin fetching from current pc; honoured only in IDLE.
- mem_cs  output  1  SRAM chip select.
- mem_addr  output  ADDR  SRAM address.
- mem_data  input  WIDTH  SRAM registered read data.
- instr  output  WIDTH  instruction register.
- instr_valid  output  1  instr holds an unconsumed instruction.
- instr_ready  input  1  consumer accepts instr this cycle.
- jump_en  input  1  redirect request; sampled only on handshake.
- jump_addr  input  ADDR  redirect target.
- pc  output  ADDR  address of next fetch.
- busy  output  1  state != IDLE.
- halted  output  1  sticky; set when a HALT_OP instruction is accepted.

Behaviour:
- Reset (async, immediate): state=IDLE; pc=0; instr=0; instr_valid=0; mem_cs=0; mem_addr=0; busy=0; halted=0. Reset mid-fetch abandons the read; the discarded SRAM data is never captured.
- States: IDLE, REQ, CAPT, VALID.
  - IDLE: mem_cs=0. On start=1 → REQ and halted cleared.
  - REQ: mem_cs=1, mem_addr=pc, both combinational from state/pc. Unconditional → CAPT.
  - CAPT: mem_cs=0; mem_data is valid this cycle. At the edge: instr<=mem_data, pc<=pc+1 (mod 2^ADDR, 15→0 wraps), instr_valid<=1, → VALID.
  - VALID: instr_valid=1 and instr stable until handshake (instr_valid & instr_ready at a rising edge). On handshake:
    - instr_valid<=0.
    - If instr opcode == HALT_OP: halted<=1, → IDLE; jump_en ignored; pc unchanged.
    - Else if jump_en: pc<=jump_addr, → REQ.
    - Else → REQ.
- mem_addr=0 whenever mem_cs=0.
- Latency: start sampled at edge E → mem_cs high in cycle E+1 → instr_valid high from edge E+2. Steady-state throughput is one instruction per 3 cycles with instr_ready held high.
- jump_en outside a handshake edge is ignored.
- start outside IDLE is ignored.
- instr_ready while instr_valid=0 has no effect.
- The SRAM is never read more than once per instruction; mem_cs is high for exactly one cycle per fetch.

Test Plan:
- Reset then start; SRAM model words 0..3 = 8'h12,8'h24,8'h50,8'h15; instr_ready=1 → instr sequence 12,24,50,15 with instr_valid rising every 3 cycles; mem_cs one-cycle pulses at addresses 0,1,2,3.
- Backpressure: instr_ready=0 for 5 cycles while instr=8'h24 valid → instr held, mem_cs stays 0, pc=2; release → handshake, next fetch at 2.
- Jump: on handshake of instr at addr 4 with jump_en=1, jump_addr=4'hA → next mem_addr=4'hA, pc then 4'hB; jump_en asserted in REQ/CAPT has no effect.
- Wrap: start with pc reaching 4'hE; word E=8'h1F, word F=8'h2F → fetch E, F, then address 0; pc wraps 15→0.
- Halt: word at pc=3 is 8'hF3 → on accept halted=1, busy=0, state IDLE, no further mem_cs; jump_en=1 on that handshake ignored; a later start clears halted and fetches from pc=4.
- Async reset asserted in CAPT (mid-cycle, between edges) → all outputs 0 immediately; after release, start fetches address 0 and the stale word is never presented.
